pmu_reader: RTL and testbench

Initiator side of the PMU register-read interface. On a start pulse it issues one read request, or a sweep of every PMU register index, to the PMU counter block. It captures each returned counter value, flags missing responses with a bounded timeout, and presents results one word at a time on a valid/ready output stream for the telemetry/report path.

---
 rtl/pmu_reader.sv | 132 +++++++++++++
 tb/tb_pmu_reader.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmu_reader.sv
// pmu_reader: initiator side of the PMU register-read interface.
// Issues one read or a sweep of every PMU register index, captures each
// returned counter value (or a zero word flagged as error on timeout) and
// hands the results out one word at a time on a valid/ready stream.
//
// Output handshake: a word is held on out_data/out_index/out_err while
// out_valid is high and transfers on the rising clock edge where
// out_valid && out_ready; the producer never drops or changes a pending word.
module pmu_reader #(
  parameter int COUNTERSIZE   = 8,
  parameter int REGISTER_SIZE = 4,
  parameter int TIMEOUT       = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mode,
  input  logic [REGISTER_SIZE-1:0] req_register,
  output logic [REGISTER_SIZE-1:0] pmu_register,
  output logic                     valid_pmu_register,
  input  logic [COUNTERSIZE-1:0]   pmu_value,
  input  logic                     valid_value,
  output logic [COUNTERSIZE-1:0]   out_data,
  output logic [REGISTER_SIZE-1:0] out_index,
  output logic                     out_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  // Timeout counter only needs to reach TIMEOUT-1 before the expiry compare.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Current FSM state; named plainly so assertions/checkers can bind to it.
  state_t                   state;
  logic                     sweep;
  logic [REGISTER_SIZE-1:0] index;
  logic [TW-1:0]            tmo_cnt;

  logic [REGISTER_SIZE-1:0] start_index;
  logic [REGISTER_SIZE-1:0] next_index;
  logic                     last_word;

  // First index of an operation, the following sweep index, and the end test.
  assign start_index = mode ? '0 : req_register;
  assign next_index  = index + REGISTER_SIZE'(1);
  assign last_word   = !sweep || (&index);

  // Request/response FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      sweep              <= 1'b0;
      index              <= '0;
      tmo_cnt            <= '0;
      pmu_register       <= '0;
      valid_pmu_register <= 1'b0;
      out_data           <= '0;
      out_index          <= '0;
      out_err            <= 1'b0;
      out_valid          <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-raised below.
      valid_pmu_register <= 1'b0;
      done               <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sweep              <= mode;
            index              <= start_index;
            pmu_register       <= start_index;
            valid_pmu_register <= 1'b1;
            busy               <= 1'b1;
            state              <= REQ;
          end
        end
        REQ: begin
          // The request strobe is visible during this cycle.
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          // A response on the final WAIT cycle still wins over the timeout.
          if (valid_value) begin
            out_data  <= pmu_value;
            out_index <= index;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= OUT;
          end else if (tmo_cnt == TMO_LAST) begin
            out_data  <= '0;
            out_index <= index;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_word) begin
              pmu_register <= '0;
              busy         <= 1'b0;
              done         <= 1'b1;
              state        <= IDLE;
            end else begin
              index              <= next_index;
              pmu_register       <= next_index;
              valid_pmu_register <= 1'b1;
              state              <= REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmu_reader.sv
// tb_pmu_reader: randomized bench for pmu_reader with a PMU stub, a ready
// driver, a monitor and a word-level scoreboard built from per-index
// response delays and values.
module tb_pmu_reader;

  localparam int CS      = 8;
  localparam int RS      = 4;
  localparam int TIMEOUT = 15;
  localparam int NIDX    = 1 << RS;
  localparam int W       = 1 + RS + CS;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          start, mode, out_ready, valid_value;
  logic [RS-1:0] req_register, pmu_register, out_index;
  logic [CS-1:0] pmu_value, out_data;
  logic          valid_pmu_register, out_err, out_valid, busy, done;

  pmu_reader #(.COUNTERSIZE(CS), .REGISTER_SIZE(RS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .req_register(req_register), .pmu_register(pmu_register),
    .valid_pmu_register(valid_pmu_register), .pmu_value(pmu_value),
    .valid_value(valid_value), .out_data(out_data), .out_index(out_index),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0]  exp_q[$];
  logic [RS-1:0] req_q[$];
  int            lat_q[$];
  logic [CS-1:0] val[NIDX];
  int            dly[NIDX];   // 0 = silent, d = respond in d-th WAIT cycle
  int  cyc = 0;
  int  done_exp = -1;
  int  done_cnt = 0;
  int  busy_cnt = 0;
  int  stall_idx = -1;
  bit  stall_done = 0;
  bit  rdy_rand = 0;
  logic model_vv = 0, stray_vv = 0;
  logic [CS-1:0] model_pv = '0;

  assign valid_value = model_vv | stray_vv;
  assign pmu_value   = model_pv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- PMU stub ----------------
  initial begin : pmu_model
    int wc;
    int widx;
    wc = 0;
    widx = 0;
    forever begin
      @(posedge clk);
      #1;
      model_vv = 1'b0;
      model_pv = CS'($urandom);
      if (!rst_n) begin
        wc = 0;
      end else begin
        if (wc == 1) begin
          model_vv = 1'b1;
          model_pv = val[widx];
          wc = 0;
        end else if (wc > 1) begin
          wc--;
        end
        if (valid_pmu_register) begin
          widx = int'(pmu_register);
          wc   = dly[widx];
        end
      end
    end
  end

  // ---------------- ready driver ----------------
  initial begin : ready_drv
    int stall_left;
    stall_left = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (out_valid && stall_idx >= 0 && int'(out_index) == stall_idx && !stall_done) begin
        out_ready  = 1'b0;
        stall_left = 4;
        stall_done = 1;
      end else begin
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    bit ov_prev, vpr_prev;
    logic [W-1:0] hold;
    int req_cyc;
    ov_prev = 0;
    vpr_prev = 0;
    hold = '0;
    req_cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (!rst_n) begin
        ov_prev = 0;
        vpr_prev = 0;
      end else begin
        if (busy) busy_cnt++;
        if (valid_pmu_register) begin
          check("req_back_to_back", 32'(vpr_prev), 0);
          check("req_during_out", 32'(out_valid), 0);
          if (req_q.size() == 0) check("req_spurious", 1, 0);
          else check("req_index", 32'(pmu_register), 32'(req_q.pop_front()));
          req_cyc = cyc;
        end
        if (out_valid) begin
          if (!ov_prev) begin
            hold = {out_err, out_index, out_data};
            if (lat_q.size() != 0) check("out_latency", cyc - req_cyc, lat_q.pop_front());
          end else begin
            check("hold_stable", 32'({out_err, out_index, out_data}), 32'(hold));
          end
          if (out_ready) begin
            if (exp_q.size() == 0) check("word_spurious", 1, 0);
            else begin
              check("word", 32'({out_err, out_index, out_data}), 32'(exp_q.pop_front()));
              if (exp_q.size() == 0) done_exp = cyc + 1;
            end
          end
        end
        if (done) begin
          check("done_cycle", cyc, done_exp);
          check("done_busy_low", 32'(busy), 0);
          done_exp = -1;
          done_cnt++;
        end
        ov_prev  = out_valid && !out_ready;
        vpr_prev = valid_pmu_register;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_op(input logic m, input logic [RS-1:0] r);
    int first, n;
    logic [RS-1:0] i4;
    first = m ? 0 : int'(r);
    n     = m ? NIDX : 1;
    for (int k = 0; k < n; k++) begin
      i4 = RS'(first + k);
      req_q.push_back(i4);
      if (dly[first + k] >= 1 && dly[first + k] <= TIMEOUT) begin
        exp_q.push_back({1'b0, i4, val[first + k]});
        lat_q.push_back(dly[first + k] + 1);
      end else begin
        exp_q.push_back({1'b1, i4, {CS{1'b0}}});
        lat_q.push_back(TIMEOUT + 1);
      end
    end
  endtask

  task automatic pulse_start(input logic m, input logic [RS-1:0] r);
    start = 1'b1;
    mode = m;
    req_register = r;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = 1'($urandom);
    req_register = RS'($urandom);
  endtask

  task automatic run_op(input logic m, input logic [RS-1:0] r, input int exp_busy, input bit poke);
    int d0;
    load_op(m, r);
    stall_done = 0;
    busy_cnt = 0;
    d0 = done_cnt;
    pulse_start(m, r);
    for (int t = 0; t < 3000 && done_cnt == d0; t++) begin
      @(posedge clk);
      #3;
      start = poke && (t == 10);
      mode = 1'b0;
      req_register = RS'(3);
    end
    start = 1'b0;
    if (done_cnt == d0) check("done_timeout", 0, 1);
    else if (exp_busy >= 0) check("busy_cycles", busy_cnt, exp_busy);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pmu_register"}, 32'(pmu_register), 0);
    check({tag, "_valid_req"}, 32'(valid_pmu_register), 0);
    check({tag, "_out_data"}, 32'(out_data), 0);
    check({tag, "_out_index"}, 32'(out_index), 0);
    check({tag, "_out_err"}, 32'(out_err), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic set_table(input int base, input int d);
    for (int i = 0; i < NIDX; i++) begin
      val[i] = CS'(base + i);
      dly[i] = d;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int pick;
    logic m;
    rst_n = 1'b0;
    start = 1'b0;
    mode = 1'b0;
    req_register = '0;
    set_table(0, 1);
    idle_cycles(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle_cycles(2);

    // Stray response while idle is ignored.
    stray_vv = 1'b1;
    idle_cycles(1);
    stray_vv = 1'b0;
    idle_cycles(1);
    check("stray_idle_valid", 32'(out_valid), 0);
    check("stray_idle_busy", 32'(busy), 0);
    check("stray_idle_data", 32'(out_data), 0);

    // Single read of index 5.
    val[5] = 8'h2A;
    run_op(1'b0, RS'(5), 3, 0);
    idle_cycles(3);

    // Plain sweep, value = index + 0x10, with a start poke mid-sweep.
    set_table(8'h10, 1);
    run_op(1'b1, '0, 3 * NIDX, 1);
    idle_cycles(5);

    // Backpressure on index 3.
    for (int i = 0; i < NIDX; i++) val[i] = CS'($urandom);
    stall_idx = 3;
    run_op(1'b1, '0, 3 * NIDX + 5, 0);
    stall_idx = -1;
    idle_cycles(2);

    // Timeout on 7, response on the timeout cycle for 2, too-late response
    // (lands in OUT) for 4.
    set_table(8'h40, 1);
    dly[7] = 0;
    dly[2] = TIMEOUT;
    dly[4] = TIMEOUT + 1;
    run_op(1'b1, '0, 3 * NIDX + 3 * (TIMEOUT - 1), 0);
    idle_cycles(2);

    // Randomized operations with random backpressure and delays.
    rdy_rand = 1;
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < NIDX; i++) begin
        val[i] = CS'($urandom);
        pick = int'($urandom_range(0, 9));
        dly[i] = (pick == 0) ? 0 : (pick == 1) ? TIMEOUT :
                 (pick == 2) ? TIMEOUT + 1 : int'($urandom_range(1, 3));
      end
      m = (it == 0) ? 1'b1 : 1'($urandom);
      run_op(m, RS'($urandom), -1, 0);
      idle_cycles(int'($urandom_range(1, 4)));
    end
    rdy_rand = 0;

    // Asynchronous reset during WAIT of index 9.
    set_table(8'h80, 1);
    dly[9] = 0;
    load_op(1'b1, '0);
    pulse_start(1'b1, '0);
    begin : find9
      bit hit;
      hit = 0;
      for (int t = 0; t < 200 && !hit; t++) begin
        @(posedge clk);
        #3;
        hit = valid_pmu_register && (pmu_register == RS'(9));
      end
      check("reach_index9", 32'(hit), 1);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    req_q.delete();
    lat_q.delete();
    done_exp = -1;
    idle_cycles(2);
    #2;
    rst_n = 1'b1;
    idle_cycles(2);
    check_all_zero("after_reset");

    // Single read behaves as before after reset.
    set_table(0, 1);
    val[5] = 8'h2A;
    run_op(1'b0, RS'(5), 3, 0);
    idle_cycles(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
